// File: rtl/seq_loader_pkg.sv
// Shared loader/control-path definitions: FSM state encoding and the default
// element and address widths also used by the datapath.
package seq_loader_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_LAUNCH   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RUN      = 3'd4
  } state_t;

endpackage

// File: rtl/seq_loader_wptr.sv
// Score-memory write pointer: increments per accepted element, clears at the
// end of a sequence, and flags when the next write lands in the last word.
module seq_loader_wptr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] wptr,
  output logic              at_max
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   wptr <= '0;
    else if (clr) wptr <= '0;
    else if (inc) wptr <= wptr + 1'b1;
  end

  assign at_max = &wptr;

endmodule

// File: rtl/seq_loader.sv
// Streams one sequence into the score memory, launches the control path with a
// single start pulse and holds off input until the control path finishes.
module seq_loader
  import seq_loader_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   seq_len,
  output logic              start,
  input  logic              cp_done,
  output logic              busy,
  output logic              err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wptr;
  logic                at_max;
  logic                hs;
  logic                wptr_inc, wptr_clr, len_load, err_set;
  logic                tcnt_clr, tcnt_inc;
  logic [TCNT_W-1:0]   tcnt;

  seq_loader_wptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk    (clk),
    .reset  (reset),
    .inc    (wptr_inc),
    .clr    (wptr_clr),
    .wptr   (wptr),
    .at_max (at_max)
  );

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign hs        = in_valid & in_ready;
  assign mem_we    = hs;
  assign mem_addr  = wptr;
  assign mem_wdata = in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      seq_len <= '0;
      tcnt    <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      // wptr+1 in ADDR_W+1 bits saturates naturally at 2**ADDR_W
      if (len_load) seq_len <= {1'b0, wptr} + (ADDR_W + 1)'(1);
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    start     = 1'b0;
    wptr_inc  = 1'b0;
    wptr_clr  = 1'b0;
    len_load  = 1'b0;
    err_set   = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        busy = (state == S_LOAD);
        if (hs) begin
          wptr_inc = 1'b1;
          // A full buffer without in_last is closed out as if it were last
          if (in_last || at_max) begin
            wptr_clr  = 1'b1;
            len_load  = 1'b1;
            err_set   = !in_last;
            state_nxt = S_LAUNCH;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LAUNCH: begin
        busy      = 1'b1;
        start     = 1'b1;
        tcnt_clr  = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        busy = 1'b1;
        if (!cp_done) begin
          state_nxt = S_RUN;
        end else if (tcnt == TCNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cp_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
